// File: rtl/z80_mem_arbiter_if.sv
// Signal bundle between the Z80 bus, the video fetcher, the shared RAM and the arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface z80_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cpu_mreq_n;
    logic          cpu_rd_n;
    logic          cpu_wr_n;
    logic          cpu_rfsh_n;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] cpu_din;
    logic          cpu_wait_n;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_data;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_addr, cpu_dout,
        output cpu_din, cpu_wait_n,
        input  vid_req, vid_addr,
        output vid_ack, vid_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_addr, cpu_dout,
        input  cpu_din, cpu_wait_n,
        output vid_req, vid_addr,
        input  vid_ack, vid_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/z80_mem_arbiter.sv
// Shares one single-port RAM (1-cycle registered read) between the Z80 bus and video fetch,
// stalling the CPU through cpu_wait_n until its access has completed.
module z80_mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int VID_PRIO = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    z80_mem_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CPU_RD, VID_RD, CPU_LAT, VID_LAT} state_t;
    typedef enum logic {GRANT_CPU, GRANT_VID} grant_t;

    state_t        state_reg,      state_next;
    grant_t        last_grant_reg, last_grant_next;
    logic          cpu_done_reg,   cpu_done_next;
    logic          mem_en_reg,     mem_en_next;
    logic          mem_we_reg,     mem_we_next;
    logic [AW-1:0] mem_addr_reg,   mem_addr_next;
    logic [DW-1:0] mem_wdata_reg,  mem_wdata_next;
    logic [DW-1:0] cpu_din_reg,    cpu_din_next;
    logic [DW-1:0] vid_data_reg,   vid_data_next;
    logic          vid_ack_reg,    vid_ack_next;

    logic cpu_act;
    logic cpu_pend;
    logic vid_pend;
    logic collide_vid;
    logic take_vid;
    logic cpu_complete;

    // Refresh and I/O cycles never qualify, so they are neither served nor stalled.
    assign cpu_act  = !bus.cpu_mreq_n && bus.cpu_rfsh_n && (!bus.cpu_rd_n || !bus.cpu_wr_n);
    assign cpu_pend = cpu_act && !cpu_done_reg;
    // The ack cycle masks the request so a requester that drops vid_req on ack is not refetched.
    assign vid_pend = bus.vid_req && !vid_ack_reg;

    always_comb begin
        collide_vid = 1'b0;
        if (VID_PRIO != 0)
            collide_vid = (last_grant_reg != GRANT_VID);
        else
            collide_vid = (last_grant_reg == GRANT_CPU);
    end

    assign take_vid = vid_pend && (!cpu_pend || collide_vid);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_CPU;
            cpu_done_reg   <= 1'b0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            cpu_din_reg    <= '0;
            vid_data_reg   <= '0;
            vid_ack_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            cpu_done_reg   <= cpu_done_next;
            mem_en_reg     <= mem_en_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            cpu_din_reg    <= cpu_din_next;
            vid_data_reg   <= vid_data_next;
            vid_ack_reg    <= vid_ack_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        mem_en_next     = 1'b0;
        mem_we_next     = 1'b0;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        cpu_din_next    = cpu_din_reg;
        vid_data_next   = vid_data_reg;
        vid_ack_next    = 1'b0;
        cpu_complete    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (take_vid) begin
                    mem_en_next     = 1'b1;
                    mem_addr_next   = bus.vid_addr;
                    last_grant_next = GRANT_VID;
                    state_next      = VID_RD;
                end else if (cpu_pend) begin
                    mem_en_next     = 1'b1;
                    mem_addr_next   = bus.cpu_addr;
                    last_grant_next = GRANT_CPU;
                    if (!bus.cpu_wr_n) begin
                        // Writes finish on issue; the CPU is released on the next cycle.
                        mem_we_next    = 1'b1;
                        mem_wdata_next = bus.cpu_dout;
                        cpu_complete   = 1'b1;
                    end else begin
                        state_next = CPU_RD;
                    end
                end
            end
            CPU_RD:  state_next = CPU_LAT;
            CPU_LAT: begin
                cpu_din_next = bus.mem_rdata;
                cpu_complete = 1'b1;
                state_next   = IDLE;
            end
            VID_RD:  state_next = VID_LAT;
            VID_LAT: begin
                vid_data_next = bus.mem_rdata;
                vid_ack_next  = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // mreq_n high wins, so a read finishing after the strobe dropped cannot block the next one.
        if (bus.cpu_mreq_n)
            cpu_done_next = 1'b0;
        else if (cpu_complete)
            cpu_done_next = 1'b1;
        else
            cpu_done_next = cpu_done_reg;
    end

    assign bus.cpu_wait_n = !reset_n || !(cpu_act && !cpu_done_reg);
    assign bus.cpu_din    = cpu_din_reg;
    assign bus.vid_ack    = vid_ack_reg;
    assign bus.vid_data   = vid_data_reg;
    assign bus.mem_en     = mem_en_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Directed bench for z80_mem_arbiter: cycle table for single accesses and a collision,
// then hand sequences for continuous video contention and reset during an access.
module tb_z80_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    // {mreq_n, rd_n, wr_n, rfsh_n}
    localparam logic [3:0] S_IDLE = 4'b1111;
    localparam logic [3:0] S_WR   = 4'b0101;
    localparam logic [3:0] S_RD   = 4'b0011;
    localparam logic [3:0] S_RFSH = 4'b0110;
    localparam logic [3:0] S_IORD = 4'b1011;
    localparam logic [3:0] S_IOWR = 4'b1101;
    localparam int NV = 22;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    z80_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    z80_mem_arbiter #(.AW(AW), .DW(DW), .VID_PRIO(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // RAM model with 1-cycle registered read; a few known words are loaded while in reset.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (!reset_n) begin
            ram[16'h3FFF] <= 8'h5C;
            ram[16'h1234] <= 8'h77;
            ram[16'h0100] <= 8'h11;
            ram[16'h0200] <= 8'h22;
        end
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic [3:0]  strb;
        logic [15:0] caddr;
        logic [7:0]  cdout;
        logic        vreq;
        logic [15:0] vaddr;
        logic        x_wait_n;
        logic        x_en;
        logic        x_we;
        logic [15:0] x_addr;
        logic [7:0]  x_wdata;
        logic        x_ack;
        logic [7:0]  x_din;
        logic [7:0]  x_vdata;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] s, input logic [15:0] ca, input logic [7:0] cd,
                                input logic vr, input logic [15:0] va, input logic xw,
                                input logic xen, input logic xwe, input logic [15:0] xa,
                                input logic [7:0] xd, input logic xack, input logic [7:0] xdin,
                                input logic [7:0] xvd);
        vec_t r;
        r.strb = s; r.caddr = ca; r.cdout = cd; r.vreq = vr; r.vaddr = va;
        r.x_wait_n = xw; r.x_en = xen; r.x_we = xwe; r.x_addr = xa; r.x_wdata = xd;
        r.x_ack = xack; r.x_din = xdin; r.x_vdata = xvd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [15:0] ca, input logic [7:0] cd,
                         input logic vr, input logic [15:0] va);
        {bus.cpu_mreq_n, bus.cpu_rd_n, bus.cpu_wr_n, bus.cpu_rfsh_n} = s;
        bus.cpu_addr = ca;
        bus.cpu_dout = cd;
        bus.vid_req  = vr;
        bus.vid_addr = va;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         n_low;
        logic       cpu_on;
        logic       last_wait;
        logic       prev_ack;
        logic [7:0] gbits;
        int         ng;

        // wait_n sampled before the edge; everything else sampled just after it.
        vecs[0]  = mk(S_WR,   16'h2400, 8'hA5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2400, 8'hA5, 1'b0, 8'h00, 8'h00);
        vecs[1]  = mk(S_WR,   16'h2400, 8'hA5, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00);
        vecs[2]  = mk(S_WR,   16'h2400, 8'hA5, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00);
        vecs[3]  = mk(S_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00);
        vecs[4]  = mk(S_RD,   16'h2400, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h2400, 8'h00, 1'b0, 8'h00, 8'h00);
        vecs[5]  = mk(S_RD,   16'h2400, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00);
        vecs[6]  = mk(S_RD,   16'h2400, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h00);
        vecs[7]  = mk(S_RD,   16'h2400, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h00);
        vecs[8]  = mk(S_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h00);
        vecs[9]  = mk(S_RFSH, 16'h0055, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h00);
        vecs[10] = mk(S_RFSH, 16'h0056, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h00);
        vecs[11] = mk(S_IORD, 16'h0010, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h00);
        vecs[12] = mk(S_IOWR, 16'h0010, 8'h3C, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h00);
        vecs[13] = mk(S_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h00);
        // Same-edge collision: video first, CPU read issued on the ack cycle.
        vecs[14] = mk(S_RD,   16'h1234, 8'h00, 1'b1, 16'h3FFF, 1'b0, 1'b1, 1'b0, 16'h3FFF, 8'h00, 1'b0, 8'hA5, 8'h00);
        vecs[15] = mk(S_RD,   16'h1234, 8'h00, 1'b1, 16'h3FFF, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h00);
        vecs[16] = mk(S_RD,   16'h1234, 8'h00, 1'b1, 16'h3FFF, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hA5, 8'h5C);
        vecs[17] = mk(S_RD,   16'h1234, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hA5, 8'h5C);
        vecs[18] = mk(S_RD,   16'h1234, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'hA5, 8'h5C);
        vecs[19] = mk(S_RD,   16'h1234, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h77, 8'h5C);
        vecs[20] = mk(S_RD,   16'h1234, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h77, 8'h5C);
        vecs[21] = mk(S_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h77, 8'h5C);

        // Reset with a CPU read strobe asserted: wait_n must still be forced high.
        reset_n = 1'b0;
        drive(S_RD, 16'h2400, 8'h00, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst.wait_n", 32'(bus.cpu_wait_n), 32'd1);
        @(posedge clk); #1;
        chk("rst.mem_en",   32'(bus.mem_en),   32'd0);
        chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst.cpu_din",  32'(bus.cpu_din),  32'd0);
        chk("rst.vid_ack",  32'(bus.vid_ack),  32'd0);
        @(negedge clk);
        drive(S_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].strb, vecs[i].caddr, vecs[i].cdout, vecs[i].vreq, vecs[i].vaddr);
            #1;
            chk($sformatf("v%0d.wait_n", i), 32'(bus.cpu_wait_n), 32'(vecs[i].x_wait_n));
            @(posedge clk); #1;
            chk($sformatf("v%0d.mem_en", i), 32'(bus.mem_en), 32'(vecs[i].x_en));
            chk($sformatf("v%0d.mem_we", i), 32'(bus.mem_we), 32'(vecs[i].x_we));
            if (vecs[i].x_en)
                chk($sformatf("v%0d.mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].x_addr));
            if (vecs[i].x_en && vecs[i].x_we)
                chk($sformatf("v%0d.mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].x_wdata));
            chk($sformatf("v%0d.vid_ack", i),  32'(bus.vid_ack),  32'(vecs[i].x_ack));
            chk($sformatf("v%0d.cpu_din", i),  32'(bus.cpu_din),  32'(vecs[i].x_din));
            chk($sformatf("v%0d.vid_data", i), 32'(bus.vid_data), 32'(vecs[i].x_vdata));
        end

        // vid_req held high while the CPU reads 0x0200 back to back: grants must alternate.
        cpu_on = 1'b0; last_wait = 1'b1; gbits = 8'h00; ng = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.vid_req  = 1'b1;
            bus.vid_addr = 16'h0100;
            if (!cpu_on) begin
                {bus.cpu_mreq_n, bus.cpu_rd_n, bus.cpu_wr_n, bus.cpu_rfsh_n} = S_RD;
                bus.cpu_addr = 16'h0200;
                cpu_on = 1'b1;
            end else if (last_wait) begin
                {bus.cpu_mreq_n, bus.cpu_rd_n, bus.cpu_wr_n, bus.cpu_rfsh_n} = S_IDLE;
                cpu_on = 1'b0;
            end
            #1;
            last_wait = bus.cpu_wait_n;
            prev_ack  = bus.vid_ack;
            @(posedge clk); #1;
            if (bus.mem_en) begin
                if (ng < 8) gbits[ng] = (bus.mem_addr == 16'h0100);
                ng++;
                if (bus.mem_addr == 16'h0100)
                    chk($sformatf("alt%0d.no_vid_issue_in_ack", c), 32'(prev_ack), 32'd0);
            end
            if (bus.vid_ack) begin
                chk($sformatf("alt%0d.ack_single", c), 32'(prev_ack), 32'd0);
                chk($sformatf("alt%0d.vid_data", c), 32'(bus.vid_data), 32'h11);
            end
        end
        chk("alt.grant_count_ge8", 32'(ng >= 8), 32'd1);
        chk("alt.grant_order", 32'(gbits), 32'h55);
        chk("alt.cpu_din", 32'(bus.cpu_din), 32'h22);

        @(negedge clk);
        drive(S_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000);
        repeat (4) @(negedge clk);

        // Reset while in CPU_RD: everything returns to reset values, nothing completes.
        drive(S_RD, 16'h2400, 8'h00, 1'b0, 16'h0000);
        @(posedge clk); #1;
        chk("rrd.issued", 32'(bus.mem_en), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rrd.wait_n_in_reset", 32'(bus.cpu_wait_n), 32'd1);
        @(posedge clk); #1;
        chk("rrd.mem_en",    32'(bus.mem_en),    32'd0);
        chk("rrd.mem_we",    32'(bus.mem_we),    32'd0);
        chk("rrd.mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rrd.mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rrd.cpu_din",   32'(bus.cpu_din),   32'd0);
        chk("rrd.vid_data",  32'(bus.vid_data),  32'd0);
        chk("rrd.vid_ack",   32'(bus.vid_ack),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(S_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rrd.after%0d.mem_en", k),  32'(bus.mem_en),  32'd0);
            chk($sformatf("rrd.after%0d.cpu_din", k), 32'(bus.cpu_din), 32'd0);
        end

        // The next read completes normally: 3 stalled edges, data valid as wait_n rises.
        @(negedge clk);
        drive(S_RD, 16'h2400, 8'h00, 1'b0, 16'h0000);
        n_low = 0;
        #1;
        while (!bus.cpu_wait_n && n_low < 10) begin
            n_low++;
            @(negedge clk); #1;
        end
        chk("rrd.read_wait_edges", 32'(n_low), 32'd3);
        chk("rrd.read_cpu_din", 32'(bus.cpu_din), 32'hA5);
        @(negedge clk);
        drive(S_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000);

        // Reset during VID_LAT: the abandoned fetch never acks.
        @(negedge clk);
        drive(S_IDLE, 16'h0000, 8'h00, 1'b1, 16'h3FFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.vid_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rvid.after%0d.vid_ack", k),  32'(bus.vid_ack),  32'd0);
            chk($sformatf("rvid.after%0d.vid_data", k), 32'(bus.vid_data), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
